// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: Moore FSM that sequences fetch/decode/execute/memory/writeback.
// Memory waits use a ready handshake; a saturating wait counter raises a timeout exception.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter bit          EN_IMM_LOGIC = 1'b1,
    parameter bit          EN_SB        = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       byte_mode,
    output logic       ir_write,
    output logic       mem2reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       exception,
    output logic [1:0] cause,
    output logic       ls_active,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StIExec    = 4'd8,
        StIWb      = 4'd9,
        StBranch   = 4'd10,
        StJump     = 4'd11,
        StExcept   = 4'd12
    } state_e;

    localparam int unsigned     CntW       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [5:0]      op_q, op_d;
    logic [1:0]      cause_q, cause_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wait_st;
    logic            timed_out;

    always_comb begin
        wait_st   = state_q inside {StFetch, StMemRead, StMemWrite};
        timed_out = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (cnt_q == TimeoutVal);
        state_d   = state_q;
        op_d      = op_q;
        cause_d   = cause_q;
        case (state_q)
            StFetch: begin
                if (timed_out) begin
                    state_d = StExcept;
                    cause_d = 2'b10;
                end else if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                op_d = opcode;
                case (opcode)
                    6'd0:                 state_d = StRExec;
                    6'd35, 6'd43:         state_d = StMemAddr;
                    6'd40:                state_d = EN_SB ? StMemAddr : StExcept;
                    6'd8:                 state_d = StIExec;
                    6'd10, 6'd12, 6'd13:  state_d = EN_IMM_LOGIC ? StIExec : StExcept;
                    6'd4, 6'd5:           state_d = StBranch;
                    6'd2:                 state_d = StJump;
                    default:              state_d = StExcept;
                endcase
                if (state_d == StExcept) cause_d = 2'b01;
            end
            StMemAddr: state_d = (op_q == 6'd35) ? StMemRead : StMemWrite;
            StMemRead, StMemWrite: begin
                if (timed_out) begin
                    state_d = StExcept;
                    cause_d = 2'b10;
                end else if (mem_ready) begin
                    state_d = (state_q == StMemRead) ? StMemWb : StFetch;
                end
            end
            StRExec:  state_d = StRWb;
            StIExec:  state_d = StIWb;
            StMemWb, StRWb, StIWb, StBranch, StJump, StExcept: state_d = StFetch;
            default:  state_d = StFetch;
        endcase

        // Counter restarts on every state change, so each wait state sees a fresh budget.
        if (state_d != state_q || !wait_st) begin
            cnt_d = '0;
        end else if (!mem_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            op_q    <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        byte_mode     = 1'b0;
        ir_write      = 1'b0;
        mem2reg       = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        exception     = 1'b0;
        ls_active     = 1'b0;
        cause         = cause_q;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode:   alu_src_b = 2'b11;
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ls_active = 1'b1;
            end
            StMemRead: begin
                mem_read  = 1'b1;
                iord      = 1'b1;
                ls_active = 1'b1;
            end
            StMemWb: begin
                reg_write = 1'b1;
                mem2reg   = 1'b1;
                ls_active = 1'b1;
            end
            StMemWrite: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                byte_mode = (op_q == 6'd40);
                ls_active = 1'b1;
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_q == 6'd8) ? 2'b00 : 2'b11;
            end
            StIWb:      reg_write = 1'b1;
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                branch_ne     = (op_q == 6'd5);
            end
            StJump: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            StExcept: begin
                exception = 1'b1;
                pc_write  = 1'b1;
                pc_src    = 2'b11;
            end
            default: ;
        endcase
        // The reset cycle must not leak any strobe or stale cause.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_ne     = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            byte_mode     = 1'b0;
            ir_write      = 1'b0;
            mem2reg       = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_src        = 2'b00;
            exception     = 1'b0;
            ls_active     = 1'b0;
            cause         = 2'b00;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: instruction-level plans expand into expected per-cycle state/output records.
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, rdy_a = 1'b0, rst_b = 1'b0, rdy_b = 1'b0;
    logic [5:0] op_a = '0, op_b = '0;
    wire  [25:0] out_a, out_b;

    multicycle_control #(.MEM_TIMEOUT(3), .EN_IMM_LOGIC(1'b1), .EN_SB(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_a), .opcode(op_a), .mem_ready(rdy_a),
        .pc_write(out_a[25]), .pc_write_cond(out_a[24]), .branch_ne(out_a[23]),
        .iord(out_a[22]), .mem_read(out_a[21]), .mem_write(out_a[20]), .byte_mode(out_a[19]),
        .ir_write(out_a[18]), .mem2reg(out_a[17]), .reg_dst(out_a[16]), .reg_write(out_a[15]),
        .alu_src_a(out_a[14]), .alu_src_b(out_a[13:12]), .alu_op(out_a[11:10]),
        .pc_src(out_a[9:8]), .exception(out_a[7]), .cause(out_a[6:5]),
        .ls_active(out_a[4]), .state(out_a[3:0])
    );

    multicycle_control #(.MEM_TIMEOUT(0), .EN_IMM_LOGIC(1'b0), .EN_SB(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b), .opcode(op_b), .mem_ready(rdy_b),
        .pc_write(out_b[25]), .pc_write_cond(out_b[24]), .branch_ne(out_b[23]),
        .iord(out_b[22]), .mem_read(out_b[21]), .mem_write(out_b[20]), .byte_mode(out_b[19]),
        .ir_write(out_b[18]), .mem2reg(out_b[17]), .reg_dst(out_b[16]), .reg_write(out_b[15]),
        .alu_src_a(out_b[14]), .alu_src_b(out_b[13:12]), .alu_op(out_b[11:10]),
        .pc_src(out_b[9:8]), .exception(out_b[7]), .cause(out_b[6:5]),
        .ls_active(out_b[4]), .state(out_b[3:0])
    );

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       rst;
        logic [1:0] cause;
        logic [5:0] op;
    } cyc_t;

    cyc_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc_n = 0;
    logic [1:0] cause_m = 2'b00;
    logic [5:0] cur_op = '0;
    int         p_t = 3;
    bit         p_sb = 1'b1;
    bit         p_imm = 1'b1;

    function automatic void push(input logic [3:0] st, input logic rdy, input logic rst);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.rst = rst; c.cause = cause_m; c.op = cur_op;
        q.push_back(c);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push_exc(input logic [1:0] cz);
        cause_m = cz;
        push(4'd12, rnd(), 1'b0);
    endfunction

    // w idle cycles then ready; a wait longer than the timeout ends in EXCEPT after T+1 cycles.
    function automatic bit push_wait(input logic [3:0] st, input int w);
        if (p_t > 0 && w > p_t) begin
            for (int i = 0; i < p_t + 1; i++) push(st, 1'b0, 1'b0);
            push_exc(2'b10);
            return 1'b0;
        end
        for (int i = 0; i < w; i++) push(st, 1'b0, 1'b0);
        push(st, 1'b1, 1'b0);
        return 1'b1;
    endfunction

    function automatic void plan(input logic [5:0] op, input int wf, input int wm);
        cur_op = op;
        if (!push_wait(4'd0, wf)) return;
        push(4'd1, rnd(), 1'b0);
        if (op == 6'd0) begin
            push(4'd6, rnd(), 1'b0); push(4'd7, rnd(), 1'b0);
        end else if (op == 6'd35) begin
            push(4'd2, rnd(), 1'b0);
            if (push_wait(4'd3, wm)) push(4'd4, rnd(), 1'b0);
        end else if (op == 6'd43 || (op == 6'd40 && p_sb)) begin
            push(4'd2, rnd(), 1'b0);
            void'(push_wait(4'd5, wm));
        end else if (op == 6'd8 || ((op == 6'd10 || op == 6'd12 || op == 6'd13) && p_imm)) begin
            push(4'd8, rnd(), 1'b0); push(4'd9, rnd(), 1'b0);
        end else if (op == 6'd4 || op == 6'd5) begin
            push(4'd10, rnd(), 1'b0);
        end else if (op == 6'd2) begin
            push(4'd11, rnd(), 1'b0);
        end else begin
            push_exc(2'b01);
        end
    endfunction

    function automatic void push_reset(input logic [3:0] st);
        push(st, rnd(), 1'b1);
        cause_m = 2'b00;
    endfunction

    function automatic logic [25:0] exp_vec(input cyc_t c);
        logic pw = 0, pwc = 0, bne = 0, io = 0, mr = 0, mw = 0, bm = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, asa = 0, exc = 0, ls = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        if (c.rst) return {22'b0, c.st};
        case (c.st)
            4'd0:  begin mr = 1; asb = 2'b01; irw = c.rdy; pw = c.rdy; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; ls = 1; end
            4'd3:  begin mr = 1; io = 1; ls = 1; end
            4'd4:  begin rw = 1; m2r = 1; ls = 1; end
            4'd5:  begin mw = 1; io = 1; bm = (c.op == 6'd40); ls = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; asb = 2'b10; aop = (c.op == 6'd8) ? 2'b00 : 2'b11; end
            4'd9:  rw = 1;
            4'd10: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; bne = (c.op == 6'd5); end
            4'd11: begin pw = 1; psrc = 2'b10; end
            4'd12: begin exc = 1; pw = 1; psrc = 2'b11; end
            default: ;
        endcase
        return {pw, pwc, bne, io, mr, mw, bm, irw, m2r, rd, rw, asa, asb, aop, psrc, exc,
                c.cause, ls, c.st};
    endfunction

    task automatic run_q(input bit sel);
        cyc_t c;
        logic [25:0] obs, expv;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            if (!sel) begin
                rst_a = !c.rst; op_a = c.op; rdy_a = c.rdy;
            end else begin
                rst_b = !c.rst; op_b = c.op; rdy_b = c.rdy;
            end
            @(negedge clk);
            obs  = sel ? out_b : out_a;
            expv = exp_vec(c);
            checks++;
            cyc_n++;
            assert (obs === expv) else begin
                failures++;
                $error("FAIL cyc%0d dut=%0d st=%0d op=%0d observed=%h expected=%h",
                       cyc_n, sel, c.st, c.op, obs, expv);
            end
        end
    endtask

    logic [5:0] ops[14] = '{6'd0, 6'd35, 6'd43, 6'd40, 6'd8, 6'd10, 6'd12, 6'd13,
                            6'd4, 6'd5, 6'd2, 6'd6, 6'd63, 6'd15};

    initial begin
        @(posedge clk);
        // Configuration A: timeout 3, all optional opcodes legal.
        p_t = 3; p_sb = 1'b1; p_imm = 1'b1; cause_m = 2'b00;
        push_reset(4'd0);
        plan(6'd0, 0, 0);
        plan(6'd35, 0, 3);
        plan(6'd40, 1, 0);
        plan(6'd5, 0, 0);
        plan(6'd4, 0, 0);
        plan(6'd2, 2, 0);
        plan(6'd12, 0, 0);
        plan(6'd8, 0, 0);
        plan(6'd0, 4, 0);
        plan(6'd0, 3, 0);
        plan(6'd43, 0, 4);
        plan(6'd63, 0, 0);
        cur_op = 6'd43;
        push(4'd0, 1'b1, 1'b0); push(4'd1, rnd(), 1'b0); push(4'd2, rnd(), 1'b0);
        push(4'd5, 1'b0, 1'b0); push_reset(4'd5);
        plan(6'd0, 0, 0);
        for (int i = 0; i < 40; i++)
            plan(ops[$urandom_range(0, 13)], $urandom_range(0, 5), $urandom_range(0, 5));
        run_q(1'b0);

        // Configuration B: no timeout, sb and logic immediates illegal.
        @(posedge clk);
        #1 rst_a = 1'b0;
        p_t = 0; p_sb = 1'b0; p_imm = 1'b0; cause_m = 2'b00;
        push_reset(4'd0);
        plan(6'd40, 0, 0);
        plan(6'd13, 0, 0);
        plan(6'd8, 0, 0);
        plan(6'd35, 10, 8);
        plan(6'd43, 0, 6);
        for (int i = 0; i < 25; i++)
            plan(ops[$urandom_range(0, 13)], $urandom_range(0, 6), $urandom_range(0, 6));
        run_q(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle successor to the single-cycle main control decoder. A Moore FSM sequences each MIPS instruction through fetch, decode, execute, memory and writeback states, driving one shared ALU and one shared memory port. Memory accesses use a ready handshake with a programmable timeout. Illegal opcodes and memory timeouts raise an exception that redirects the PC to the exception vector. The block sits between the instruction register's opcode field and the multicycle datapath muxes and enables.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready per access; 0 disables the timeout
EN_IMM_LOGIC, 1, 1: slti/andi/ori legal; 0: they are illegal opcodes
EN_SB, 1, 1: sb (opcode 40) legal; 0: illegal

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until the next FETCH completes
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition true
branch_ne  out  1  1 = take branch on ALU non-zero (bne), 0 = on zero (beq)
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
byte_mode  out  1  store is a byte store (sb)
ir_write  out  1  load IR
mem2reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
reg_dst  out  1  destination register: 1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  ALU A input: 0 = PC, 1 = rs
alu_src_b  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = immediate op
pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector
exception  out  1  one-cycle pulse on entering EXCEPT
cause  out  2  01 = illegal opcode, 10 = memory timeout; held until the next exception
ls_active  out  1  current state is MEM_ADDR, MEM_READ, MEM_WB or MEM_WRITE
state  out  4  current state encoding, for debug

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, EXCEPT 12. Encodings 13-15 go to FETCH.
- Reset (rst_n low at edge): state = FETCH, cause = 00, internal opcode latch = 0, wait counter = 0. Every output not listed as asserted in a state is 0.
- FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_write and pc_write are asserted only in the cycle mem_ready = 1; the FSM then moves to DECODE.
  - Otherwise the FSM waits in FETCH.
- DECODE: alu_src_b = 11, alu_op = 00 (precomputes the branch target). The opcode is latched into op_q here. Next state by opcode:
  - 0 -> R_EXEC
  - 35 and 43 -> MEM_ADDR; 40 -> MEM_ADDR when EN_SB = 1
  - 8 -> I_EXEC; 10, 12, 13 -> I_EXEC when EN_IMM_LOGIC = 1
  - 4 and 5 -> BRANCH
  - 2 -> JUMP
  - anything else -> EXCEPT with cause = 01
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state: MEM_READ if op_q = 35, else MEM_WRITE.
- MEM_READ: mem_read = 1, iord = 1. Goes to MEM_WB on mem_ready.
- MEM_WB: reg_write = 1, mem2reg = 1, reg_dst = 0. Next state FETCH.
- MEM_WRITE: mem_write = 1, iord = 1, byte_mode = (op_q == 40). Goes to FETCH on mem_ready.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next R_WB.
- R_WB: reg_write = 1, reg_dst = 1. Next FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00 for addi, 11 for slti/andi/ori. Next I_WB.
- I_WB: reg_write = 1, reg_dst = 0. Next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_src = 01, branch_ne = (op_q == 5). Next FETCH.
- JUMP: pc_write = 1, pc_src = 10. Next FETCH.
- EXCEPT: exception = 1, pc_write = 1, pc_src = 11. Next FETCH.
- Latency with zero wait states:
  - R-type 4 cycles, lw 5, sw/sb 4, addi/logic-immediate 4, beq/bne 3, j 3.
  - Each wait state adds 1 cycle.
- Timeout (MEM_TIMEOUT > 0):
  - The counter clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each cycle mem_ready = 0 in those states.
  - When the counter equals MEM_TIMEOUT and mem_ready = 0, the next state is EXCEPT with cause = 10, and no ir_write/pc_write is issued for that fetch.
  - mem_ready = 1 on the timeout cycle wins: normal completion, no exception.
- The counter width is clog2(MEM_TIMEOUT+1), minimum 1. It saturates and never wraps.
- Reset asserted mid-instruction aborts it; the next state is FETCH and no write strobes are asserted in the reset cycle.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.

Test Plan:
- R-type, mem_ready tied 1 -> states 0,1,6,7,0; reg_write = 1 and reg_dst = 1 only in state 7; alu_op = 10 in state 6.
- lw (35) with mem_ready low for 3 cycles in MEM_READ -> 8 cycles total; mem2reg = 1 and reg_write = 1 in state 4; ls_active = 1 for states 2-4.
- sb (40) with EN_SB = 1 -> byte_mode = 1 and mem_write = 1 in state 5. Rerun with EN_SB = 0 -> EXCEPT, cause = 01, pc_src = 11.
- bne (5) -> pc_write_cond = 1, branch_ne = 1, alu_op = 01 in state 10. j (2) -> pc_write = 1, pc_src = 10 in state 11.
- MEM_TIMEOUT = 3, mem_ready held 0 in FETCH -> EXCEPT after 4 FETCH cycles, exception pulses once, cause = 10, ir_write never asserted. Repeat with mem_ready = 1 on the 4th cycle -> DECODE, no exception.
- rst_n low during MEM_WRITE -> state = 0 next cycle, mem_write = 0 during reset, cause = 00.
